issue_queue: RTL

Parametrised in-order issue stage for the Tomasulo core. It buffers decoded instructions in a DEPTH-entry FIFO and reads source operands (label + value) for the head entry from the register/status file. It applies same-cycle CDB bypass and dispatches the head to one of NUM_CLASS reservation-station classes over a valid/ready handshake. On dispatch it renames the destination register to the tag supplied by the accepting station.

---
 rtl/tomasulo_pkg.sv | 24 ++
 rtl/operand_bypass.sv | 31 +++
 rtl/issue_queue.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: widths, ready label, station classes, opcodes.
package tomasulo_pkg;
  localparam int LABEL_W    = 4;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  // A zero label marks an operand whose value is already available.
  localparam logic [LABEL_W-1:0] LABEL_READY = '0;

  // Reservation-station class encodings.
  localparam int CLASS_ALU = 0;
  localparam int CLASS_MEM = 1;

  // selALU opcodes.
  localparam logic [5:0] SEL_ADD = 6'd0;
  localparam logic [5:0] SEL_SUB = 6'd1;
  localparam logic [5:0] SEL_LW  = 6'd8;
  localparam logic [5:0] SEL_SW  = 6'd9;

  // Class select width; a single class still needs one bit.
  function automatic int cls_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/operand_bypass.sv
// Forms one source operand from the status-file read plus same-cycle CDB bypass.
module operand_bypass #(
  parameter int LABEL_W = tomasulo_pkg::LABEL_W,
  parameter int DATA_W  = tomasulo_pkg::DATA_W
) (
  input  logic [tomasulo_pkg::REG_ADDR_W-1:0] addr,
  input  logic [LABEL_W-1:0]                  label_in,
  input  logic [DATA_W-1:0]                   data_in,
  input  logic                                cdb_valid,
  input  logic [LABEL_W-1:0]                  cdb_label,
  input  logic [DATA_W-1:0]                   cdb_value,
  output logic [LABEL_W-1:0]                  label,
  output logic [DATA_W-1:0]                   value
);
  import tomasulo_pkg::*;

  localparam logic [LABEL_W-1:0] READY = LABEL_W'(LABEL_READY);

  // r0 reads as ready zero; a pending tag matching the broadcast resolves this cycle.
  always_comb begin
    label = label_in;
    value = data_in;
    if (addr == '0) begin
      label = READY;
      value = '0;
    end else if (label_in != READY && cdb_valid && cdb_label == label_in) begin
      label = READY;
      value = cdb_value;
    end
  end
endmodule

// File: rtl/issue_queue.sv
// In-order issue stage: FIFO of decoded instructions, head operand read with
// CDB bypass, one-hot dispatch to a station class and destination rename on fire.
module issue_queue #(
  parameter int DEPTH     = 4,
  parameter int NUM_CLASS = 2,
  parameter int LABEL_W   = tomasulo_pkg::LABEL_W,
  parameter int DATA_W    = tomasulo_pkg::DATA_W,
  localparam int CLS_W    = tomasulo_pkg::cls_width(NUM_CLASS),
  localparam int RA_W     = tomasulo_pkg::REG_ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CLS_W-1:0]             in_class,
  input  logic [5:0]                   in_selALU,
  input  logic [RA_W-1:0]              in_rs,
  input  logic [RA_W-1:0]              in_rt,
  input  logic [RA_W-1:0]              in_target,
  input  logic                         in_wb,
  input  logic [DATA_W-1:0]            in_imm,
  output logic [RA_W-1:0]              readAddr1,
  output logic [RA_W-1:0]              readAddr2,
  input  logic [LABEL_W-1:0]           labelIn1,
  input  logic [LABEL_W-1:0]           labelIn2,
  input  logic [DATA_W-1:0]            dataIn1,
  input  logic [DATA_W-1:0]            dataIn2,
  input  logic                         cdb_valid,
  input  logic [LABEL_W-1:0]           cdb_label,
  input  logic [DATA_W-1:0]            cdb_value,
  output logic [NUM_CLASS-1:0]         disp_valid,
  input  logic [NUM_CLASS-1:0]         disp_ready,
  input  logic [NUM_CLASS*LABEL_W-1:0] disp_tag,
  output logic [5:0]                   selALU,
  output logic [LABEL_W-1:0]           label1,
  output logic [LABEL_W-1:0]           label2,
  output logic [DATA_W-1:0]            value1,
  output logic [DATA_W-1:0]            value2,
  output logic [RA_W-1:0]              target,
  output logic [DATA_W-1:0]            Imm,
  output logic                         rename_we,
  output logic [RA_W-1:0]              rename_addr,
  output logic [LABEL_W-1:0]           rename_label
);
  import tomasulo_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [CLS_W-1:0]  cls;
    logic [5:0]        sel;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   target;
    logic              wb;
    logic [DATA_W-1:0] imm;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              empty, full, push, fire;
  logic [LABEL_W-1:0] head_tag;

  logic [1:0][RA_W-1:0]    src_addr;
  logic [1:0][LABEL_W-1:0] src_label_in, src_label;
  logic [1:0][DATA_W-1:0]  src_data_in, src_value;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && !full && !flush;

  // Head is masked to zero while empty so every payload output idles at 0.
  assign head = empty ? '0 : mem[rd_ptr];

  // One-hot dispatch on the head's class; an out-of-range class matches nothing and stalls.
  always_comb begin
    disp_valid = '0;
    head_tag   = '0;
    for (int c = 0; c < NUM_CLASS; c++) begin
      if (head.cls == CLS_W'(c)) begin
        disp_valid[c] = !empty && !flush;
        head_tag      = disp_tag[c*LABEL_W +: LABEL_W];
      end
    end
  end

  assign fire = |(disp_valid & disp_ready);

  assign readAddr1 = head.rs;
  assign readAddr2 = head.rt;
  assign selALU    = head.sel;
  assign target    = head.target;
  assign Imm       = head.imm;

  // Destination takes the accepting station's tag; r0 is never renamed.
  assign rename_we    = fire && head.wb && (head.target != '0);
  assign rename_addr  = rename_we ? head.target : '0;
  assign rename_label = rename_we ? head_tag : '0;

  assign src_addr     = {head.rt, head.rs};
  assign src_label_in = {labelIn2, labelIn1};
  assign src_data_in  = {dataIn2, dataIn1};

  for (genvar i = 0; i < 2; i++) begin : g_src
    operand_bypass #(.LABEL_W(LABEL_W), .DATA_W(DATA_W)) u_byp (
      .addr      (src_addr[i]),
      .label_in  (src_label_in[i]),
      .data_in   (src_data_in[i]),
      .cdb_valid (cdb_valid),
      .cdb_label (cdb_label),
      .cdb_value (cdb_value),
      .label     (src_label[i]),
      .value     (src_value[i])
    );
  end

  assign label1 = src_label[0];
  assign label2 = src_label[1];
  assign value1 = src_value[0];
  assign value2 = src_value[1];

  // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fire) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Entry storage; left unreset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{cls: in_class, sel: in_selALU, rs: in_rs, rt: in_rt,
                       target: in_target, wb: in_wb, imm: in_imm};
  end
endmodule
